// File: rtl/mon_pkg.sv
// Shared definitions for the PC checkpoint monitor: FSM states, status codes
// and the parameter defaults used by the top level and the slot sub-module.
package mon_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NCHK_DEF  = 4;
    localparam int TMO_W_DEF = 24;
    localparam int MODE_DEF  = 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_PASS = 3'd2,
        ST_FAIL = 3'd3,
        ST_TMO  = 3'd4
    } state_e;

    localparam logic [1:0] STAT_NONE = 2'b00;
    localparam logic [1:0] STAT_PASS = 2'b01;
    localparam logic [1:0] STAT_FAIL = 2'b10;
    localparam logic [1:0] STAT_TMO  = 2'b11;

    // Status code reported while the FSM sits in a given state.
    function automatic logic [1:0] state_status(input state_e s);
        case (s)
            ST_PASS: state_status = STAT_PASS;
            ST_FAIL: state_status = STAT_FAIL;
            ST_TMO:  state_status = STAT_TMO;
            default: state_status = STAT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/chk_slot.sv
// One checkpoint slot: holds its configuration, shadows the watched register
// and flags whether the current sample hits this slot with a good or bad value.
module chk_slot
    import mon_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cfg_wr,
    input  logic            cfg_en,
    input  logic [XLEN-1:0] cfg_pc,
    input  logic [4:0]      cfg_reg,
    input  logic [XLEN-1:0] cfg_val,
    input  logic            rf_we,
    input  logic [4:0]      rf_waddr,
    input  logic [XLEN-1:0] rf_wdata,
    input  logic            sample_en,
    input  logic [XLEN-1:0] pc,
    input  logic            hit,
    output logic            en,
    output logic            cand_match,
    output logic            cand_mismatch,
    output logic [XLEN-1:0] obs_val
);

    logic            en_q;
    logic [XLEN-1:0] pc_q;
    logic [4:0]      reg_q;
    logic [XLEN-1:0] val_q;
    logic [XLEN-1:0] shadow_q;
    logic            cand;

    // Configuration registers, loaded only when the top accepts a write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_q  <= 1'b0;
            pc_q  <= '0;
            reg_q <= '0;
            val_q <= '0;
        end else if (cfg_wr) begin
            en_q  <= cfg_en;
            pc_q  <= cfg_pc;
            reg_q <= cfg_reg;
            val_q <= cfg_val;
        end
    end

    // Shadow of the watched register; a reconfiguration starts it from zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_q <= '0;
        end else if (cfg_wr) begin
            shadow_q <= '0;
        end else if (rf_we && (rf_waddr == reg_q) && (rf_waddr != 5'd0)) begin
            shadow_q <= rf_wdata;
        end
    end

    // Candidate detect and compare against the registered shadow (x0 reads 0).
    always_comb begin
        obs_val       = (reg_q == 5'd0) ? '0 : shadow_q;
        cand          = en_q && !hit && sample_en && (pc == pc_q);
        cand_match    = cand && (obs_val == val_q);
        cand_mismatch = cand && (obs_val != val_q);
    end

    assign en = en_q;

endmodule

// File: rtl/pc_check_monitor.sv
// PC checkpoint monitor: watches core-state samples, checks register values at
// configured PCs and reports pass, fail or timeout through registered outputs.
module pc_check_monitor
    import mon_pkg::*;
#(
    parameter int  XLEN  = XLEN_DEF,
    parameter int  NCHK  = NCHK_DEF,
    parameter int  TMO_W = TMO_W_DEF,
    parameter int  MODE  = MODE_DEF,
    localparam int IDXW  = (NCHK > 1) ? $clog2(NCHK) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_en,
    input  logic [XLEN-1:0]  pc,
    input  logic             rf_we,
    input  logic [4:0]       rf_waddr,
    input  logic [XLEN-1:0]  rf_wdata,
    input  logic             cfg_we,
    input  logic [IDXW-1:0]  cfg_idx,
    input  logic             cfg_en,
    input  logic [XLEN-1:0]  cfg_pc,
    input  logic [4:0]       cfg_reg,
    input  logic [XLEN-1:0]  cfg_val,
    input  logic [TMO_W-1:0] tmo_max,
    input  logic             start,
    input  logic             clear,
    output logic             busy,
    output logic             done,
    output logic [1:0]       status,
    output logic [IDXW-1:0]  fail_idx,
    output logic [XLEN-1:0]  fail_val,
    output logic [NCHK-1:0]  hit_mask,
    output logic [TMO_W-1:0] sample_cnt
);

    state_e           state_q, state_d;
    logic [NCHK-1:0]  hit_mask_q, hit_mask_d;
    logic [TMO_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [IDXW-1:0]  fail_idx_q, fail_idx_d;
    logic [XLEN-1:0]  fail_val_q, fail_val_d;
    logic             busy_q, done_q;
    logic [1:0]       status_q;

    logic [NCHK-1:0]  en_vec, match_vec, mismatch_vec;
    logic [XLEN-1:0]  obs_val [NCHK];
    logic             sample_run;
    logic [IDXW-1:0]  pe_idx;
    logic [XLEN-1:0]  pe_val;
    logic [NCHK-1:0]  hits_now;
    logic [TMO_W-1:0] cnt_inc;
    logic             pass_now, tmo_now;

    assign sample_run = sample_en && (state_q == ST_RUN);

    for (genvar gi = 0; gi < NCHK; gi++) begin : g_slot
        logic slot_wr;
        assign slot_wr = cfg_we && (state_q == ST_IDLE) && (cfg_idx == IDXW'(gi));
        chk_slot #(.XLEN(XLEN)) u_slot (
            .clk           (clk),
            .reset         (reset),
            .cfg_wr        (slot_wr),
            .cfg_en        (cfg_en),
            .cfg_pc        (cfg_pc),
            .cfg_reg       (cfg_reg),
            .cfg_val       (cfg_val),
            .rf_we         (rf_we),
            .rf_waddr      (rf_waddr),
            .rf_wdata      (rf_wdata),
            .sample_en     (sample_run),
            .pc            (pc),
            .hit           (hit_mask_q[gi]),
            .en            (en_vec[gi]),
            .cand_match    (match_vec[gi]),
            .cand_mismatch (mismatch_vec[gi]),
            .obs_val       (obs_val[gi])
        );
    end

    // Lowest-index mismatching slot and the value it observed.
    always_comb begin
        pe_idx = '0;
        pe_val = '0;
        for (int i = NCHK - 1; i >= 0; i--) begin
            if (mismatch_vec[i]) begin
                pe_idx = IDXW'(i);
                pe_val = obs_val[i];
            end
        end
    end

    // Next-state logic: run control, hit tracking, counter and fail capture.
    always_comb begin
        state_d      = state_q;
        hit_mask_d   = hit_mask_q;
        sample_cnt_d = sample_cnt_q;
        fail_idx_d   = fail_idx_q;
        fail_val_d   = fail_val_q;

        hits_now = hit_mask_q | match_vec;
        cnt_inc  = (&sample_cnt_q) ? sample_cnt_q : sample_cnt_q + TMO_W'(1);
        if (MODE == 0) begin
            pass_now = |match_vec;
        end else begin
            pass_now = (|match_vec) && ((hits_now & en_vec) == en_vec);
        end
        tmo_now = (tmo_max != '0) && (cnt_inc == tmo_max);

        case (state_q)
            ST_IDLE: begin
                if (start && (|en_vec)) begin
                    state_d      = ST_RUN;
                    hit_mask_d   = '0;
                    sample_cnt_d = '0;
                    fail_idx_d   = '0;
                    fail_val_d   = '0;
                end
            end
            ST_RUN: begin
                if (sample_run) begin
                    sample_cnt_d = cnt_inc;
                    hit_mask_d   = hits_now;
                    if (|mismatch_vec) begin
                        state_d    = ST_FAIL;
                        fail_idx_d = pe_idx;
                        fail_val_d = pe_val;
                    end else if (pass_now) begin
                        state_d = ST_PASS;
                    end else if (tmo_now) begin
                        state_d = ST_TMO;
                    end
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase

        if (clear) begin
            state_d      = ST_IDLE;
            hit_mask_d   = '0;
            sample_cnt_d = '0;
            fail_idx_d   = '0;
            fail_val_d   = '0;
        end
    end

    // State and output registers; flags are decoded from the next state so
    // they change on the same edge as the state itself.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            hit_mask_q   <= '0;
            sample_cnt_q <= '0;
            fail_idx_q   <= '0;
            fail_val_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            status_q     <= STAT_NONE;
        end else begin
            state_q      <= state_d;
            hit_mask_q   <= hit_mask_d;
            sample_cnt_q <= sample_cnt_d;
            fail_idx_q   <= fail_idx_d;
            fail_val_q   <= fail_val_d;
            busy_q       <= (state_d == ST_RUN);
            done_q       <= (state_d == ST_PASS) || (state_d == ST_FAIL) || (state_d == ST_TMO);
            status_q     <= state_status(state_d);
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign status     = status_q;
    assign fail_idx   = fail_idx_q;
    assign fail_val   = fail_val_q;
    assign hit_mask   = hit_mask_q;
    assign sample_cnt = sample_cnt_q;

endmodule

// File: tb/tb_pc_check_monitor.sv
// Self-checking bench for pc_check_monitor: a cycle table for the basic
// pass/fail/hazard flow, hand-written multi-cycle sequences, and a random
// phase compared against a behavioural model of the checkpoint rules.
module tb_pc_check_monitor;

    localparam int MODE = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_en, rf_we, cfg_we, cfg_en, start, clear;
    logic [31:0] pc, rf_wdata, cfg_pc, cfg_val;
    logic [4:0]  rf_waddr, cfg_reg;
    logic [1:0]  cfg_idx;
    logic [23:0] tmo_max;
    logic        busy, done;
    logic [1:0]  status;
    logic [1:0]  fail_idx;
    logic [31:0] fail_val;
    logic [3:0]  hit_mask;
    logic [23:0] sample_cnt;

    int total_cnt = 0;
    int pass_cnt  = 0;

    pc_check_monitor #(.XLEN(32), .NCHK(4), .TMO_W(24), .MODE(MODE)) dut (
        .clk(clk), .reset(reset), .sample_en(sample_en), .pc(pc),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_pc(cfg_pc),
        .cfg_reg(cfg_reg), .cfg_val(cfg_val), .tmo_max(tmo_max),
        .start(start), .clear(clear), .busy(busy), .done(done),
        .status(status), .fail_idx(fail_idx), .fail_val(fail_val),
        .hit_mask(hit_mask), .sample_cnt(sample_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_strobes();
        sample_en = 0; rf_we = 0; cfg_we = 0; start = 0; clear = 0;
    endtask

    task automatic cfg_write(input int idx, input bit en, input logic [31:0] p,
                             input logic [4:0] r, input logic [31:0] v);
        cfg_we = 1; cfg_idx = 2'(idx); cfg_en = en; cfg_pc = p; cfg_reg = r; cfg_val = v;
        step();
        cfg_we = 0;
    endtask

    task automatic rf_write(input logic [4:0] a, input logic [31:0] d);
        rf_we = 1; rf_waddr = a; rf_wdata = d;
        step();
        rf_we = 0;
    endtask

    task automatic do_sample(input logic [31:0] p);
        sample_en = 1; pc = p;
        step();
        sample_en = 0;
    endtask

    task automatic pulse_start();
        start = 1; step(); start = 0;
    endtask

    task automatic pulse_clear();
        clear = 1; step(); clear = 0;
    endtask

    task automatic chk_flags(input string name, input logic [1:0] st, input logic b, input logic d);
        check({name, ".status"}, status, st);
        check({name, ".busy"}, busy, b);
        check({name, ".done"}, done, d);
        $display("txn %s: status=%b busy=%b done=%b hit=%b cnt=%0d", name, status, busy, done, hit_mask, sample_cnt);
    endtask

    // ---------------- cycle table ----------------
    typedef struct {
        logic        smp;
        logic [31:0] pcv;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        st;
        logic        clr;
        logic [1:0]  e_status;
        logic        e_busy;
        logic        e_done;
        logic        c_hit;
        logic [3:0]  e_hit;
        logic        c_fail;
        logic [1:0]  e_fidx;
        logic [31:0] e_fval;
    } vec_t;

    vec_t tbl[17];

    // ---------------- behavioural model ----------------
    logic [31:0] m_rf [32];
    bit          m_fresh [4];
    bit          m_en [4];
    logic [31:0] m_pc [4];
    logic [31:0] m_val [4];
    logic [4:0]  m_reg [4];
    bit          m_act;
    logic [1:0]  m_stat;
    logic [3:0]  m_hits;
    int          m_cnt;
    int          m_fidx;
    logic [31:0] m_fval;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = 0;
        for (int i = 0; i < 4; i++) begin
            m_fresh[i] = 0; m_en[i] = 0; m_pc[i] = 0; m_val[i] = 0; m_reg[i] = 0;
        end
        m_act = 0; m_stat = 0; m_hits = 0; m_cnt = 0; m_fidx = 0; m_fval = 0;
    endtask

    // Applies the current inputs to the model as one clock edge.
    task automatic model_edge();
        logic [31:0] shv [4];
        bit idle_pre, any_en, all_hit;
        int first_bad;
        idle_pre = !m_act && (m_stat == 0);
        any_en = 0;
        for (int i = 0; i < 4; i++) begin
            shv[i] = (m_reg[i] != 0 && m_fresh[i]) ? m_rf[m_reg[i]] : 32'h0;
            if (m_en[i]) any_en = 1;
        end
        if (clear) begin
            m_act = 0; m_stat = 0;
        end else if (idle_pre) begin
            if (start && any_en) begin
                m_act = 1; m_hits = 0; m_cnt = 0;
            end
        end else if (m_act && sample_en) begin
            if (m_cnt < 24'hffffff) m_cnt++;
            first_bad = -1;
            for (int i = 0; i < 4; i++) begin
                if (m_en[i] && !m_hits[i] && pc == m_pc[i]) begin
                    if (shv[i] == m_val[i]) m_hits[i] = 1;
                    else if (first_bad < 0) first_bad = i;
                end
            end
            all_hit = 1;
            for (int i = 0; i < 4; i++) if (m_en[i] && !m_hits[i]) all_hit = 0;
            if (first_bad >= 0) begin
                m_act = 0; m_stat = 2'b10; m_fidx = first_bad; m_fval = shv[first_bad];
            end else if ((MODE == 0) ? (m_hits != 0 && shv[0] === shv[0]) : all_hit) begin
                m_act = 0; m_stat = 2'b01;
            end else if (tmo_max != 0 && m_cnt == int'(tmo_max)) begin
                m_act = 0; m_stat = 2'b11;
            end
        end
        if (rf_we && rf_waddr != 0) begin
            m_rf[rf_waddr] = rf_wdata;
            for (int i = 0; i < 4; i++) if (m_reg[i] == rf_waddr) m_fresh[i] = 1;
        end
        if (idle_pre && cfg_we) begin
            m_en[cfg_idx] = cfg_en; m_pc[cfg_idx] = cfg_pc; m_reg[cfg_idx] = cfg_reg;
            m_val[cfg_idx] = cfg_val; m_fresh[cfg_idx] = 0;
        end
    endtask

    logic [31:0] pcs [3];

    initial begin
        reset = 1;
        zero_strobes();
        pc = 0; rf_waddr = 0; rf_wdata = 0; cfg_idx = 0; cfg_en = 0;
        cfg_pc = 0; cfg_reg = 0; cfg_val = 0; tmo_max = 0;
        #2 reset = 0;
        #1;
        chk_flags("reset", 2'b00, 0, 0);
        check("reset.hit", hit_mask, 0);
        check("reset.cnt", sample_cnt, 0);
        check("reset.fidx", fail_idx, 0);
        check("reset.fval", fail_val, 0);
        step(); step();
        reset = 1;
        step();

        // ---- table: pass, fail, same-cycle hazard, clear/start interplay ----
        cfg_write(0, 1, 32'h20, 5'd5, 32'hffffffaa);
        //            smp pcv     we wa  wd           st clr  stat  b  d  ch hit  cf fi   fv
        tbl[0]  = '{0, 32'h00, 1, 5, 32'hffffffaa, 0, 0, 2'b00, 0, 0, 1, 4'h0, 0, 2'd0, 32'h0};
        tbl[1]  = '{0, 32'h00, 0, 0, 32'h0,        1, 0, 2'b00, 1, 0, 1, 4'h0, 0, 2'd0, 32'h0};
        tbl[2]  = '{1, 32'h10, 0, 0, 32'h0,        0, 0, 2'b00, 1, 0, 1, 4'h0, 0, 2'd0, 32'h0};
        tbl[3]  = '{1, 32'h20, 0, 0, 32'h0,        0, 0, 2'b01, 0, 1, 1, 4'h1, 0, 2'd0, 32'h0};
        tbl[4]  = '{0, 32'h00, 0, 0, 32'h0,        1, 0, 2'b01, 0, 1, 1, 4'h1, 0, 2'd0, 32'h0};
        tbl[5]  = '{0, 32'h00, 0, 0, 32'h0,        0, 1, 2'b00, 0, 0, 0, 4'h0, 0, 2'd0, 32'h0};
        tbl[6]  = '{0, 32'h00, 1, 5, 32'hffffff55, 0, 0, 2'b00, 0, 0, 0, 4'h0, 0, 2'd0, 32'h0};
        tbl[7]  = '{0, 32'h00, 0, 0, 32'h0,        1, 0, 2'b00, 1, 0, 1, 4'h0, 0, 2'd0, 32'h0};
        tbl[8]  = '{1, 32'h20, 0, 0, 32'h0,        0, 0, 2'b10, 0, 1, 1, 4'h0, 1, 2'd0, 32'hffffff55};
        tbl[9]  = '{0, 32'h00, 0, 0, 32'h0,        0, 1, 2'b00, 0, 0, 0, 4'h0, 0, 2'd0, 32'h0};
        tbl[10] = '{0, 32'h00, 0, 0, 32'h0,        1, 0, 2'b00, 1, 0, 1, 4'h0, 0, 2'd0, 32'h0};
        tbl[11] = '{1, 32'h20, 1, 5, 32'hffffffaa, 0, 0, 2'b10, 0, 1, 1, 4'h0, 1, 2'd0, 32'hffffff55};
        tbl[12] = '{0, 32'h00, 0, 0, 32'h0,        1, 1, 2'b00, 0, 0, 0, 4'h0, 0, 2'd0, 32'h0};
        tbl[13] = '{0, 32'h00, 0, 0, 32'h0,        1, 1, 2'b00, 0, 0, 0, 4'h0, 0, 2'd0, 32'h0};
        tbl[14] = '{0, 32'h00, 0, 0, 32'h0,        1, 0, 2'b00, 1, 0, 1, 4'h0, 0, 2'd0, 32'h0};
        tbl[15] = '{1, 32'h20, 0, 0, 32'h0,        0, 0, 2'b01, 0, 1, 1, 4'h1, 0, 2'd0, 32'h0};
        tbl[16] = '{0, 32'h00, 0, 0, 32'h0,        0, 1, 2'b00, 0, 0, 0, 4'h0, 0, 2'd0, 32'h0};
        for (int r = 0; r < 17; r++) begin
            sample_en = tbl[r].smp; pc = tbl[r].pcv;
            rf_we = tbl[r].we; rf_waddr = tbl[r].wa; rf_wdata = tbl[r].wd;
            start = tbl[r].st; clear = tbl[r].clr;
            step();
            zero_strobes();
            chk_flags($sformatf("row%0d", r), tbl[r].e_status, tbl[r].e_busy, tbl[r].e_done);
            if (tbl[r].c_hit) check($sformatf("row%0d.hit", r), hit_mask, tbl[r].e_hit);
            if (tbl[r].c_fail) begin
                check($sformatf("row%0d.fidx", r), fail_idx, tbl[r].e_fidx);
                check($sformatf("row%0d.fval", r), fail_val, tbl[r].e_fval);
            end
        end

        // ---- timeout after 16 samples ----
        tmo_max = 24'd16;
        pulse_start();
        for (int i = 1; i <= 16; i++) begin
            do_sample(32'h30);
            if (i < 16) check($sformatf("tmo.busy%0d", i), busy, 1);
        end
        chk_flags("tmo16", 2'b11, 0, 1);
        check("tmo16.cnt", sample_cnt, 16);
        pulse_clear();

        // ---- timeout disabled: 1000 samples stay busy ----
        tmo_max = 24'd0;
        pulse_start();
        for (int i = 0; i < 1000; i++) do_sample(32'h30);
        chk_flags("notmo", 2'b00, 1, 0);
        check("notmo.cnt", sample_cnt, 1000);
        pulse_clear();

        // ---- pass on the sample that reaches the budget wins over timeout ----
        tmo_max = 24'd3;
        pulse_start();
        do_sample(32'h30);
        do_sample(32'h30);
        do_sample(32'h20);
        chk_flags("tmo_vs_pass", 2'b01, 0, 1);
        check("tmo_vs_pass.cnt", sample_cnt, 3);
        pulse_clear();
        tmo_max = 24'd0;

        // ---- two slots on one pc: slot 1 mismatches ----
        cfg_write(0, 1, 32'h40, 5'd5, 32'hffffffaa);
        cfg_write(1, 1, 32'h40, 5'd6, 32'h00001234);
        rf_write(5'd5, 32'hffffffaa);
        rf_write(5'd6, 32'h00009999);
        pulse_start();
        do_sample(32'h40);
        chk_flags("dual_fail", 2'b10, 0, 1);
        check("dual_fail.fidx", fail_idx, 1);
        check("dual_fail.fval", fail_val, 32'h9999);
        check("dual_fail.hit", hit_mask, 4'b0001);
        pulse_clear();
        rf_write(5'd6, 32'h00001234);
        pulse_start();
        do_sample(32'h40);
        chk_flags("dual_pass", 2'b01, 0, 1);
        check("dual_pass.hit", hit_mask, 4'b0011);
        pulse_clear();

        // ---- all-slots rule across two different pcs ----
        cfg_write(1, 1, 32'h44, 5'd6, 32'h00001234);
        rf_write(5'd6, 32'h00001234);
        pulse_start();
        do_sample(32'h40);
        chk_flags("partial", 2'b00, 1, 0);
        check("partial.hit", hit_mask, 4'b0001);
        do_sample(32'h44);
        chk_flags("partial_done", 2'b01, 0, 1);
        check("partial_done.hit", hit_mask, 4'b0011);
        pulse_clear();

        // ---- x0 slot ignores writes to x0; cfg write during RUN ignored ----
        cfg_write(0, 0, 32'h40, 5'd5, 32'h0);
        cfg_write(1, 0, 32'h44, 5'd6, 32'h0);
        cfg_write(2, 1, 32'h50, 5'd0, 32'h0);
        rf_write(5'd0, 32'hdeadbeef);
        pulse_start();
        cfg_write(2, 1, 32'h50, 5'd0, 32'h5);
        do_sample(32'h50);
        chk_flags("x0", 2'b01, 0, 1);
        check("x0.hit", hit_mask, 4'b0100);
        pulse_clear();

        // ---- start with nothing enabled is ignored ----
        cfg_write(2, 0, 32'h50, 5'd0, 32'h0);
        pulse_start();
        chk_flags("noen_start", 2'b00, 0, 0);

        // ---- reset in the middle of a run ----
        cfg_write(0, 1, 32'h20, 5'd5, 32'hffffffaa);
        rf_write(5'd5, 32'hffffffaa);
        pulse_start();
        do_sample(32'h30);
        chk_flags("pre_rst", 2'b00, 1, 0);
        reset = 0;
        #1;
        chk_flags("mid_rst", 2'b00, 0, 0);
        check("mid_rst.cnt", sample_cnt, 0);
        step();
        reset = 1;
        do_sample(32'h20);
        chk_flags("post_rst", 2'b00, 0, 0);
        pulse_start();
        chk_flags("post_rst_start", 2'b00, 0, 0);

        // ---- randomized phase against the model ----
        reset = 0;
        step();
        reset = 1;
        model_reset();
        tmo_max = 0;
        pcs[0] = 32'h20; pcs[1] = 32'h24; pcs[2] = 32'h28;
        for (int n = 0; n < 600; n++) begin
            sample_en = ($urandom % 2) == 0;
            pc        = pcs[$urandom % 3];
            rf_we     = ($urandom % 3) == 0;
            rf_waddr  = 5'($urandom % 4);
            rf_wdata  = $urandom % 3;
            cfg_we    = ($urandom % 4) == 0;
            cfg_idx   = 2'($urandom % 4);
            cfg_en    = ($urandom % 4) != 0;
            cfg_pc    = pcs[$urandom % 3];
            cfg_reg   = 5'($urandom % 4);
            cfg_val   = $urandom % 3;
            start     = ($urandom % 6) == 0;
            clear     = ($urandom % 25) == 0;
            if (($urandom % 40) == 0)
                tmo_max = (($urandom % 2) == 0) ? 24'd0 : 24'($urandom_range(2, 12));
            model_edge();
            step();
            check($sformatf("rnd%0d.status", n), status, m_stat);
            check($sformatf("rnd%0d.busy", n), busy, m_act);
            check($sformatf("rnd%0d.done", n), done, m_stat != 0);
            if (m_act || m_stat != 0) begin
                check($sformatf("rnd%0d.hit", n), hit_mask, m_hits);
                check($sformatf("rnd%0d.cnt", n), sample_cnt, m_cnt);
            end
            if (m_stat == 2'b10) begin
                check($sformatf("rnd%0d.fidx", n), fail_idx, m_fidx);
                check($sformatf("rnd%0d.fval", n), fail_val, m_fval);
            end
            $display("rnd %0d: status=%b busy=%b hit=%b cnt=%0d", n, status, busy, hit_mask, sample_cnt);
        end
        zero_strobes();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
